mul_div_unit: RTL and testbench

- Multiply/divide unit in the E stage; owns the HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- The E-stage control decodes the instruction into `op`/`start` and supplies forwarded operands (E_v1, E_v2).
- `busy` and `start` feed ClashControl, which stalls D while an md/mf/mt instruction would conflict.
- `hi`/`lo` outputs feed the E-stage result mux for MFHI/MFLO.

---
 rtl/mul_div_unit.sv | 146 ++++++++++++++
 tb/tb_mul_div_unit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// E-stage multiply/divide unit owning HI/LO. Long ops latch their result at
// acceptance and commit it to HI/LO when the busy countdown expires.
module mul_div_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] d1,
   input  logic [31:0] d2,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {ST_IDLE, ST_RUN} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [63:0]        hold_q, hold_d;
   logic               hold_vld_q, hold_vld_d;
   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;

   logic               accept_c;
   logic               long_op_c;
   logic signed [63:0] a_sx, b_sx;
   logic [63:0]        prod_s, prod_u;
   logic [31:0]        div_b;
   logic [31:0]        a_mag, b_mag, q_mag, r_mag;
   logic [31:0]        q_s, r_s, q_u, r_u;

   assign accept_c  = start && (state_q == ST_IDLE) && (op != 3'd0) && (op != 3'd7);
   assign long_op_c = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);

   // Arithmetic; divides use a guarded divisor since a zero divisor never commits
   always_comb begin
      a_sx   = {{32{d1[31]}}, d1};
      b_sx   = {{32{d2[31]}}, d2};
      prod_s = 64'(a_sx * b_sx);
      prod_u = 64'({32'd0, d1} * {32'd0, d2});
      div_b  = (d2 == 32'd0) ? 32'd1 : d2;
      q_u    = d1 / div_b;
      r_u    = d1 % div_b;
      a_mag  = d1[31] ? 32'(32'd0 - d1) : d1;
      b_mag  = div_b[31] ? 32'(32'd0 - div_b) : div_b;
      q_mag  = a_mag / b_mag;
      r_mag  = a_mag % b_mag;
      q_s    = (d1[31] ^ div_b[31]) ? 32'(32'd0 - q_mag) : q_mag;
      r_s    = d1[31] ? 32'(32'd0 - r_mag) : r_mag;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept_c && long_op_c) state_d = ST_RUN;
         ST_RUN:  if (cnt_q == CNT_W'(1))    state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d      = cnt_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               case (op)
                  OP_MTHI:  hi_d = d1;
                  OP_MTLO:  lo_d = d1;
                  OP_MULT: begin
                     hold_d     = prod_s;
                     hold_vld_d = 1'b1;
                     cnt_d      = CNT_W'(MULT_CYCLES);
                  end
                  OP_MULTU: begin
                     hold_d     = prod_u;
                     hold_vld_d = 1'b1;
                     cnt_d      = CNT_W'(MULT_CYCLES);
                  end
                  OP_DIV: begin
                     hold_d     = {r_s, q_s};
                     hold_vld_d = (d2 != 32'd0);
                     cnt_d      = CNT_W'(DIV_CYCLES);
                  end
                  OP_DIVU: begin
                     hold_d     = {r_u, q_u};
                     hold_vld_d = (d2 != 32'd0);
                     cnt_d      = CNT_W'(DIV_CYCLES);
                  end
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               hold_vld_d = 1'b0;
               if (hold_vld_q) {hi_d, lo_d} = hold_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q      <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         cnt_q      <= cnt_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit with hand-computed HI/LO results.
module tb_mul_div_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] d1, d2;
   logic        busy;
   logic [31:0] hi, lo;

   int n_cmp = 0;
   int n_err = 0;

   mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .d1    (d1),
      .d2    (d2),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; op = o; d1 = a; d2 = b;
      @(posedge clk); #1;
      start = 1'b0; op = 3'd0;
   endtask

   // Issue a long op, count busy cycles, verify HI/LO hold then final values
   task automatic run_long(input string tag, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input int n_exp,
                           input logic [31:0] hi_exp, input logic [31:0] lo_exp);
      logic [31:0] hi_old, lo_old;
      logic        hold_ok;
      int          n;
      hi_old  = hi;
      lo_old  = lo;
      hold_ok = 1'b1;
      n       = 0;
      issue(o, a, b);
      check({tag, "_busy_rise"}, 64'(busy), 64'd1);
      while (busy && n < 100) begin
         if (hi !== hi_old || lo !== lo_old) hold_ok = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_cycles"}, 64'(n), 64'(n_exp));
      check({tag, "_hold"}, 64'(hold_ok), 64'd1);
      check({tag, "_hi"}, 64'(hi), 64'(hi_exp));
      check({tag, "_lo"}, 64'(lo), 64'(lo_exp));
   endtask

   initial begin
      int n;
      rst = 1'b0; start = 1'b0; op = 3'd0; d1 = '0; d2 = '0;
      #12;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      @(negedge clk); rst = 1'b1;

      run_long("mult_neg", 3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_long("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
      run_long("mult_m1sq", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'h0000_0000, 32'h0000_0001);
      run_long("div_neg", 3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_long("divu", 3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
      run_long("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);

      issue(3'd5, 32'h0000_AAAA, 32'd0);
      check("mthi_hi", 64'(hi), 64'h0000_AAAA);
      check("mthi_busy", 64'(busy), 64'd0);
      issue(3'd6, 32'h0000_5555, 32'd0);
      check("mtlo_lo", 64'(lo), 64'h0000_5555);
      check("mtlo_hi", 64'(hi), 64'h0000_AAAA);
      check("mtlo_busy", 64'(busy), 64'd0);

      run_long("div0", 3'd3, 32'd1234, 32'd0, 10, 32'h0000_AAAA, 32'h0000_5555);
      run_long("divu0", 3'd4, 32'd1234, 32'd0, 10, 32'h0000_AAAA, 32'h0000_5555);

      // MTHI held high across a MULT busy window only takes effect after busy falls
      issue(3'd1, 32'h0001_0000, 32'h0001_0000);
      n = 0;
      while (busy && n < 100) begin
         if (n == 2) begin
            start = 1'b1; op = 3'd5; d1 = 32'h0000_1234;
         end
         @(posedge clk); #1;
         n++;
      end
      check("ign_cycles", 64'(n), 64'd5);
      check("ign_hi_fall", 64'(hi), 64'h0000_0001);
      check("ign_lo_fall", 64'(lo), 64'h0000_0000);
      @(posedge clk); #1;
      start = 1'b0; op = 3'd0;
      check("ign_hi_after", 64'(hi), 64'h0000_1234);
      check("ign_busy_after", 64'(busy), 64'd0);

      // Asynchronous reset in the third DIV busy cycle aborts the op
      issue(3'd6, 32'h0000_5555, 32'd0);
      issue(3'd3, 32'd100, 32'd7);
      @(posedge clk); #1;
      @(posedge clk); #3;
      check("abort_busy_pre", 64'(busy), 64'd1);
      rst = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_hi", 64'(hi), 64'd0);
      check("abort_lo", 64'(lo), 64'd0);
      @(negedge clk); rst = 1'b1;
      n = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) n++;
      end
      check("abort_no_late", 64'(n), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
